// File: rtl/exibe_sequencia.sv
// Plays back addresses 0..limite of a 16x4 sync ROM on the LEDs: each value lit T_ACESO clocks, then blank T_APAGADO clocks.
// Latency: 2 + T_ACESO + T_APAGADO clocks per value; pronto pulses one clock after the last value; no backpressure.
module exibe_sequencia #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] ULT_ACESO   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] ULT_APAGADO = TW'(T_APAGADO - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    PREPARA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    endereco_q, endereco_d;
  logic [3:0]    limite_q, limite_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= 4'h0;
      limite_q   <= 4'h0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    timer_d    = timer_q;
    leds       = 4'h0;
    exibindo   = 1'b1;
    pronto     = 1'b0;
    case (estado_q)
      INICIAL: begin
        exibindo   = 1'b0;
        endereco_d = 4'h0;
        if (iniciar) begin
          limite_d = limite;
          estado_d = PREPARA;
        end
      end
      // ROM output for the current address becomes valid during this clock
      PREPARA: begin
        timer_d  = '0;
        estado_d = ACENDE;
      end
      ACENDE: begin
        leds = dado_mem;
        if (timer_q == ULT_ACESO) begin
          timer_d  = '0;
          estado_d = APAGA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGA: begin
        if (timer_q == ULT_APAGADO) begin
          timer_d  = '0;
          estado_d = PROXIMO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PROXIMO: begin
        timer_d = '0;
        if (endereco_q == limite_q) begin
          estado_d = FIM;
        end else begin
          endereco_d = endereco_q + 4'h1;
          estado_d   = PREPARA;
        end
      end
      FIM: begin
        exibindo   = 1'b0;
        pronto     = 1'b1;
        endereco_d = 4'h0;
        estado_d   = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign endereco  = endereco_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: timeline model indexed by cycles since the start edge, plus literal checks of key timings.
module tb_exibe_sequencia;
  localparam int TA = 3;
  localparam int TB = 2;
  localparam int P  = 2 + TA + TB;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [3:0] limite, dado_mem, endereco, leds, db_estado;
  logic       exibindo, pronto;
  logic [3:0] rom [16];

  exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TB)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
    .dado_mem(dado_mem), .endereco(endereco), .leds(leds),
    .exibindo(exibindo), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // synchronous ROM: data valid one clock after the address
  always @(posedge clock) dado_mem <= rom[endereco];

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model: a run is a timeline of (limite+1) slots of P clocks each, then one completion clock
  bit         act = 1'b0;
  int         t = 0, lim = 0;
  logic [3:0] snap [16];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      act <= 1'b0;
      t   <= 0;
      lim <= 0;
    end else if (!act) begin
      if (iniciar) begin
        act  <= 1'b1;
        t    <= 1;
        lim  <= int'(limite);
        snap <= rom;
      end
    end else if (t == (lim + 1) * P + 1) begin
      act <= 1'b0;
    end else begin
      t <= t + 1;
    end
  end

  // {db_estado, leds, endereco, pronto, exibindo}
  function automatic logic [13:0] ref_out(input bit a, input int tt, input int l);
    int idx, ph;
    ref_out = '0;
    if (a) begin
      if (tt == (l + 1) * P + 1) begin
        ref_out = {4'hF, 4'h0, 4'(l), 2'b10};
      end else begin
        idx = (tt - 1) / P;
        ph  = (tt - 1) % P;
        if (ph == 0)            ref_out = {4'h1, 4'h0, 4'(idx), 2'b01};
        else if (ph <= TA)      ref_out = {4'h2, snap[idx], 4'(idx), 2'b01};
        else if (ph <= TA + TB) ref_out = {4'h3, 4'h0, 4'(idx), 2'b01};
        else                    ref_out = {4'h4, 4'h0, 4'(idx), 2'b01};
      end
    end
  endfunction

  bit chk_en = 1'b0;

  always @(negedge clock) begin
    logic [13:0] e;
    if (chk_en) begin
      e = ref_out(act, t, lim);
      check("db_estado", db_estado, e[13:10]);
      check("leds", leds, e[9:6]);
      check("endereco", endereco, e[5:2]);
      check("pronto", pronto, e[1]);
      check("exibindo", exibindo, e[0]);
    end
  end

  // run observers for the directed literal checks
  int         ncyc = 0, e0 = 0;
  int         npronto = 0, pronto_at = 0, max_end = 0, first_on = -1;
  logic [3:0] trace [$];

  always @(posedge clock) ncyc <= ncyc + 1;

  always @(negedge clock) begin
    if (pronto) begin
      npronto   = npronto + 1;
      pronto_at = ncyc - e0 + 1;
    end
    if (exibindo && int'(endereco) > max_end) max_end = int'(endereco);
    if (leds != 4'h0) begin
      trace.push_back(leds);
      if (first_on < 0) first_on = ncyc - e0 + 1;
    end
  end

  task automatic start(input logic [3:0] l);
    @(negedge clock);
    limite  = l;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    e0 = ncyc;
    npronto = 0;
    max_end = 0;
    first_on = -1;
    trace.delete();
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_pronto(input int budget);
    int k = 0;
    while (npronto == 0 && k < budget) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("pronto_seen", npronto, 1);
  endtask

  task automatic wait_state(input logic [3:0] st, input logic [3:0] adr, input int budget);
    int k = 0;
    while (!(db_estado == st && endereco == adr) && k < budget) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("state_reached", {db_estado, endereco}, {st, adr});
  endtask

  int hold = 0;

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    limite = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_estado", db_estado, 4'h0);
    check("rst_leds", leds, 4'h0);
    check("rst_endereco", endereco, 4'h0);
    check("rst_pronto", pronto, 1'b0);
    check("rst_exibindo", exibindo, 1'b0);
    @(negedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // idle with iniciar low
    repeat (20) @(negedge clock);
    #1;
    check("idle_estado", db_estado, 4'h0);

    // single value, limite = 0
    rom[0] = 4'h5;
    start(4'h0);
    wait_pronto(50);
    check("t2_pronto_at", pronto_at, 8);
    check("t2_first_on", first_on, 2);
    check("t2_len", trace.size(), 3);
    for (int i = 0; i < trace.size(); i++) check("t2_val", trace[i], 4'h5);
    repeat (2) @(negedge clock);
    #1;
    check("t2_end_back", endereco, 4'h0);

    // four values
    rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h4; rom[3] = 4'h8;
    start(4'h3);
    wait_pronto(100);
    check("t3_pronto_at", pronto_at, 29);
    check("t3_len", trace.size(), 12);
    for (int i = 0; i < trace.size(); i++) check("t3_val", trace[i], 32'(1 << (i / 3)));
    check("t3_max_end", max_end, 3);

    // all sixteen addresses
    for (int i = 0; i < 16; i++) rom[i] = 4'((i % 15) + 1);
    start(4'hF);
    wait_pronto(200);
    check("t4_pronto_at", pronto_at, 113);
    check("t4_len", trace.size(), 48);
    check("t4_max_end", max_end, 15);

    // reset in the middle of ACENDE at address 2
    start(4'h3);
    wait_state(4'h2, 4'h2, 100);
    #2 reset = 1'b1;
    #1;
    check("t5_leds", leds, 4'h0);
    check("t5_endereco", endereco, 4'h0);
    check("t5_estado", db_estado, 4'h0);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    npronto = 0;
    repeat (40) @(negedge clock);
    #1;
    check("t5_no_pronto", npronto, 0);

    // start request and limite change during APAGA are ignored
    start(4'h1);
    wait_state(4'h3, 4'h0, 50);
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'h7;
    @(negedge clock);
    iniciar = 1'b0;
    wait_pronto(100);
    repeat (20) @(negedge clock);
    #1;
    check("t6_pronto_cnt", npronto, 1);
    check("t6_pronto_at", pronto_at, 15);
    check("t6_max_end", max_end, 1);

    // randomized start requests, held starts, limite changes, ROM updates and resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      #1;
      if (hold == 0 && $urandom_range(0, 59) == 0) hold = $urandom_range(1, 40);
      iniciar = (hold > 0) || ($urandom_range(0, 11) == 0);
      if (hold > 0) hold--;
      limite = 4'($urandom);
      if (!act && $urandom_range(0, 3) == 0) rom[$urandom_range(0, 15)] = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    iniciar = 1'b0;
    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Presentation side of the memory game. The existing datapath reads the stored sequence and compares it against the player's keys; this block reads the same 16x4 sync ROM and plays the sequence back on the LEDs.
- On `iniciar` it walks addresses 0..`limite`. For each address it lights the LEDs with the ROM value for `T_ACESO` clocks, then blanks them for `T_APAGADO` clocks.
- When the last address has been shown it pulses `pronto`. The game control unit then hands over to the player-input phase.

Parameters:
- `T_ACESO`, 500: clocks each value is shown on the LEDs. Must be >= 1.
- `T_APAGADO`, 250: clocks the LEDs stay blank between values. Must be >= 1.

Ports:
- `clock`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `iniciar`, input, 1: start request; sampled only in INICIAL.
- `limite`, input, 4: last address to show, inclusive; registered on start.
- `dado_mem`, input, 4: ROM `data_out`; valid one clock after `endereco` changes.
- `endereco`, output, 4: ROM address.
- `leds`, output, 4: displayed value; 0 when blank.
- `exibindo`, output, 1: 1 in every state except INICIAL and FIM.
- `pronto`, output, 1: single-cycle completion pulse.
- `db_estado`, output, 4: state code, for debug.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - Go to INICIAL.
  - Clear `endereco`, the registered limit and the timer.
  - `leds`=0, `pronto`=0, `exibindo`=0.
- States and `db_estado` codes: INICIAL=0, PREPARA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=4'hF.
- INICIAL:
  - Idle; `endereco` is held at 0.
  - If `iniciar`=1 at an edge: register `limite`, clear `endereco`, go to PREPARA.
- PREPARA:
  - Lasts exactly 1 clock and covers the ROM read latency.
  - Clear the timer; go to ACENDE.
- ACENDE:
  - `leds`=`dado_mem` (combinational from state; the ROM output is stable because `endereco` is constant).
  - Timer counts 0..`T_ACESO`-1; on the last count, clear the timer and go to APAGA.
  - Lasts exactly `T_ACESO` clocks.
- APAGA:
  - `leds`=0.
  - Lasts exactly `T_APAGADO` clocks, then go to PROXIMO.
- PROXIMO:
  - Lasts 1 clock.
  - If `endereco` equals the registered limit: go to FIM.
  - Otherwise: `endereco` <= `endereco`+1 and go to PREPARA.
- FIM:
  - `pronto`=1 for exactly this one clock; go to INICIAL.
  - `endereco` returns to 0 on entry to INICIAL.
- Timing per shown value: 2 + `T_ACESO` + `T_APAGADO` clocks.
- Completion latency: with `iniciar` sampled at edge e0, `pronto` is high during cycle (`limite`+1)·(2+`T_ACESO`+`T_APAGADO`) + 1 after e0.
- Start conditions:
  - `iniciar` is ignored outside INICIAL, whether pulsed or held.
  - If `iniciar` is still held high on return to INICIAL, a new run starts on the next edge (level-sensitive).
  - Changes to `limite` during a run have no effect.
- `limite`=15: all 16 addresses are shown; `endereco` never wraps past 15.
- `limite`=0: exactly one value is shown.
- The timer is sized from the larger parameter and is cleared on every entry to ACENDE and APAGA.
- There are no combinational paths from inputs to `pronto` or `exibindo`.

Test Plan:
1. Reset, then idle with `iniciar`=0 → `db_estado`=0, `leds`=0, `endereco`=0, `pronto`=0 held indefinitely.
2. `T_ACESO`=3, `T_APAGADO`=2, ROM[0]=4'h5, `limite`=0, 1-cycle `iniciar` → `leds`=5 for exactly 3 clocks starting 2 clocks after the start edge, then 0 for 2 clocks; `pronto` high 1 clock, 8 cycles after the start edge; `endereco` back to 0.
3. Same parameters, ROM = 1,2,4,8, `limite`=3 → `leds` shows 1,2,4,8 in order, each for 3 clocks with 2-clock gaps; `endereco` steps 0..3; `pronto` at cycle 29.
4. `limite`=15 → all 16 ROM values shown; `endereco` reaches 15 with no wrap to 0 before `pronto`.
5. Assert `reset` during ACENDE at address 2 → same cycle `leds`=0, `endereco`=0, `db_estado`=0; no `pronto` pulse follows.
6. Pulse `iniciar` and change `limite` from 1 to 7 while in APAGA → no restart; the sequence stops after address 1; a single `pronto` pulse.
